// File: rtl/uart_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_arb_pkg
// Purpose  : Shared types and constants for the UART transmit arbiter.
//            - arb_state_t : arbiter sequencing states
//            - UART_DW     : width of one UART byte
//            - NREQ_MAX    : largest supported requester count
//            - id_w()      : index width needed to address n items
// Revision : 1.0  initial release
// ============================================================================
package uart_arb_pkg;

  localparam int UART_DW  = 8;
  localparam int NREQ_MAX = 8;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD    = 3'd1,
    SEND    = 3'd2,
    WAIT_HI = 3'd3,
    WAIT_LO = 3'd4
  } arb_state_t;

  // Width of an index able to address n items (at least 1 bit).
  function automatic int id_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_tx_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// Module   : rr_pick
// Purpose  : Combinational round-robin selector. Returns the first asserted
//            bit of 'valid' found at or after 'ptr', wrapping NREQ-1 -> 0.
// Ports    : valid  [NREQ]  request vector
//            ptr    [IW]    highest-priority index this round
//            winner [IW]    selected index (0 when none valid)
//            any    [1]     at least one request is valid
// Revision : 1.0  initial release
// ============================================================================
module rr_pick #(
  parameter int NREQ = 4,
  parameter int IW   = 2
) (
  input  logic [NREQ-1:0] valid,
  input  logic [IW-1:0]   ptr,
  output logic [IW-1:0]   winner,
  output logic            any
);

  // Scan from farthest to nearest rotation offset so the nearest valid
  // requester is the one left in 'winner'.
  always_comb begin
    winner = '0;
    any    = 1'b0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (valid[(int'(ptr) + k) % NREQ]) begin
        winner = IW'((int'(ptr) + k) % NREQ);
        any    = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_arbiter
// Purpose  : Shares one UART transmitter (data_in/send/busy) among NREQ byte
//            sources. Round-robin grant with a packet lock: the owner keeps the
//            transmitter until its byte tagged 'last' has been shifted out.
//            Each byte gets a one-cycle send pulse, then the busy rise and fall
//            are awaited before the next byte is offered.
// Ports    : clk, rst_n            clock, async active-low reset
//            req_valid/data/last   per-requester byte offer (data at [8*i +: 8])
//            req_ready             one-hot accept to the current owner
//            tx_data, tx_send      to transmitter data_in / send
//            tx_busy               from transmitter busy
//            grant_id, active      current/last owner and packet-lock flag
//            timeout_err           one-cycle pulse on lock release by timeout
// Options  : UART_ARB_TIMEOUT_EN   releases a lock whose owner stalls in LOAD
//                                  for TIMEOUT_CYC cycles
// Revision : 1.0  initial release
// ============================================================================
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int NREQ        = 4,
  parameter int BUSY_WAIT   = 4,
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [NREQ*UART_DW-1:0] req_data,
  input  logic [NREQ-1:0]         req_last,
  output logic [NREQ-1:0]         req_ready,
  output logic [UART_DW-1:0]      tx_data,
  output logic                    tx_send,
  input  logic                    tx_busy,
  output logic [$clog2(NREQ)-1:0] grant_id,
  output logic                    active,
  output logic                    timeout_err
);

  localparam int IW = id_w(NREQ);
  localparam int BW = id_w(BUSY_WAIT);

  arb_state_t         state_q, state_d;
  logic [IW-1:0]      grant_q, grant_d;
  logic [IW-1:0]      ptr_q, ptr_d;
  logic               active_q, active_d;
  logic [UART_DW-1:0] tx_data_q, tx_data_d;
  logic               last_q, last_d;
  logic [BW-1:0]      wait_cnt_q, wait_cnt_d;

  logic [IW-1:0]      pick_id;
  logic               pick_any;
  logic               owner_valid;
  logic [IW-1:0]      next_ptr;

`ifdef UART_ARB_TIMEOUT_EN
  localparam int TW = id_w(TIMEOUT_CYC);
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic          timeout_err_q, timeout_err_d;
`endif

  rr_pick #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_pick (
    .valid  (req_valid),
    .ptr    (ptr_q),
    .winner (pick_id),
    .any    (pick_any)
  );

  assign owner_valid = req_valid[grant_q];
  // After a packet the owner drops to lowest priority.
  assign next_ptr    = (grant_q == IW'(NREQ - 1)) ? '0 : grant_q + 1'b1;

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    ptr_d      = ptr_q;
    active_d   = active_q;
    tx_data_d  = tx_data_q;
    last_d     = last_q;
    wait_cnt_d = wait_cnt_q;
    req_ready  = '0;
    tx_send    = 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
    to_cnt_d      = '0;
    timeout_err_d = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (pick_any) begin
          grant_d  = pick_id;
          active_d = 1'b1;
          state_d  = LOAD;
        end
      end
      LOAD: begin
        // A foreign frame may still be shifting; hold off until it finishes.
        if (owner_valid && !tx_busy) begin
          req_ready[grant_q] = 1'b1;
          tx_data_d          = req_data[int'(grant_q)*UART_DW +: UART_DW];
          last_d             = req_last[grant_q];
          state_d            = SEND;
        end
`ifdef UART_ARB_TIMEOUT_EN
        else if (!owner_valid) begin
          if (to_cnt_q == TW'(TIMEOUT_CYC - 1)) begin
            active_d      = 1'b0;
            ptr_d         = next_ptr;
            timeout_err_d = 1'b1;
            state_d       = IDLE;
          end else begin
            to_cnt_d = to_cnt_q + 1'b1;
          end
        end else begin
          to_cnt_d = to_cnt_q;
        end
`endif
      end
      SEND: begin
        tx_send    = 1'b1;
        wait_cnt_d = '0;
        state_d    = WAIT_HI;
      end
      WAIT_HI: begin
        // A transmitter that never raises busy must not hang the arbiter.
        if (tx_busy || (wait_cnt_q == BW'(BUSY_WAIT - 1))) begin
          state_d = WAIT_LO;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      WAIT_LO: begin
        if (!tx_busy) begin
          if (last_q) begin
            active_d = 1'b0;
            ptr_d    = next_ptr;
            state_d  = IDLE;
          end else begin
            state_d = LOAD;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      ptr_q      <= '0;
      active_q   <= 1'b0;
      tx_data_q  <= '0;
      last_q     <= 1'b0;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      ptr_q      <= ptr_d;
      active_q   <= active_d;
      tx_data_q  <= tx_data_d;
      last_q     <= last_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

`ifdef UART_ARB_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt_q      <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      to_cnt_q      <= to_cnt_d;
      timeout_err_q <= timeout_err_d;
    end
  end
  assign timeout_err = timeout_err_q;
`else
  // No timeout in this build: the lock persists; evaluates to 0 for every
  // legal TIMEOUT_CYC.
  assign timeout_err = (TIMEOUT_CYC < 0);
`endif

  assign tx_data  = tx_data_q;
  assign grant_id = grant_q;
  assign active   = active_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_arbiter
// Purpose  : Self-checking bench for uart_tx_arbiter. Stimulus pushes expected
//            (byte, owner) pairs into a queue in round-robin packet order; a
//            monitor pops and compares on every send pulse and checks that
//            ready only ever goes to the owner of the next expected byte.
// Revision : 1.0  initial release
// ============================================================================
module tb_uart_tx_arbiter;

  localparam int NREQ      = 4;
  localparam int BUSY_WAIT = 4;
`ifdef UART_ARB_TIMEOUT_EN
  localparam int TIMEOUT_CYC = 50;
`else
  localparam int TIMEOUT_CYC = 100000;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  req_valid, req_last, req_ready;
  logic [31:0] req_data;
  logic [7:0]  tx_data;
  logic        tx_send, tx_busy;
  logic [1:0]  grant_id;
  logic        active, timeout_err;

  logic model_busy = 1'b0;
  logic foreign_busy = 1'b0;
  assign tx_busy = model_busy | foreign_busy;

  bit stuck = 1'b0;
  int busy_len = 0;
  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int ptr_m = 0;
  logic prev_send = 1'b0;

  typedef struct {
    logic [7:0] d;
    int         id;
  } exp_t;
  exp_t exp_q[$];
  exp_t e_mon;
  int   send_t[$];

  uart_tx_arbiter #(
    .NREQ        (NREQ),
    .BUSY_WAIT   (BUSY_WAIT),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_last    (req_last),
    .req_ready   (req_ready),
    .tx_data     (tx_data),
    .tx_send     (tx_send),
    .tx_busy     (tx_busy),
    .grant_id    (grant_id),
    .active      (active),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic fail(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s: got no/unexpected event, required the expected event", name);
  endtask

  // Transmitter model: busy rises the cycle after send, stays high busy_len
  // cycles (random when 0). In stuck mode busy never rises.
  initial begin
    forever begin
      @(negedge clk);
      if (tx_send && !stuck) begin
        @(posedge clk);
        #1 model_busy = 1'b1;
        repeat (busy_len > 0 ? busy_len : $urandom_range(2, 8)) @(posedge clk);
        #1 model_busy = 1'b0;
      end
    end
  end

  // Scoreboard monitor.
  always @(negedge clk) begin
    if (rst_n) begin
      if (tx_send) begin
        send_t.push_back(cyc);
        chk("send_single_cycle", {31'd0, prev_send}, 32'd0);
        if (exp_q.size() == 0) begin
          fail("unexpected_send");
        end else begin
          e_mon = exp_q.pop_front();
          chk("tx_data", {24'd0, tx_data}, {24'd0, e_mon.d});
          chk("send_owner", {30'd0, grant_id}, e_mon.id);
        end
      end
      if (req_ready != 4'd0) begin
        if (exp_q.size() == 0) fail("unexpected_ready");
        else chk("ready_owner", {28'd0, req_ready}, 32'd1 << exp_q[0].id);
      end
      prev_send = tx_send;
    end else begin
      prev_send = 1'b0;
    end
  end

  task automatic wait_idle();
    int g = 0;
    do begin
      @(negedge clk);
      g++;
    end while ((exp_q.size() != 0 || active) && g < 3000);
    if (g >= 3000) fail("wait_idle_timeout");
  endtask

  // One packet per masked requester, all offered in the same cycle while the
  // arbiter is idle: expected order is plain rotation from the model pointer.
  task automatic run_phase(input logic [3:0] mask, input bit gaps, input int flen);
    logic [7:0] pk [4][8];
    int   len [4];
    int   idx [4];
    int   gap [4];
    logic [3:0] acc;
    int   last_r = 0;
    int   guard = 0;
    bit   pending;
    exp_t e;
    for (int r = 0; r < 4; r++) begin
      len[r] = (flen > 0) ? flen : $urandom_range(1, 4);
      idx[r] = 0;
      gap[r] = 0;
      for (int b = 0; b < 8; b++) pk[r][b] = 8'($urandom_range(0, 255));
    end
    for (int k = 0; k < 4; k++) begin
      int r = (ptr_m + k) % 4;
      if (mask[r]) begin
        for (int b = 0; b < len[r]; b++) begin
          e.d  = pk[r][b];
          e.id = r;
          exp_q.push_back(e);
        end
        last_r = r;
      end
    end
    ptr_m = (last_r + 1) % 4;
    @(posedge clk);
    #1;
    pending = 1'b1;
    while (pending && guard < 3000) begin
      pending = 1'b0;
      for (int r = 0; r < 4; r++) begin
        if (mask[r] && idx[r] < len[r]) begin
          pending = 1'b1;
          if (gap[r] > 0) begin
            req_valid[r] = 1'b0;
            gap[r]--;
          end else begin
            req_valid[r]       = 1'b1;
            req_data[8*r +: 8] = pk[r][idx[r]];
            req_last[r]        = (idx[r] == len[r] - 1);
          end
        end else begin
          req_valid[r] = 1'b0;
        end
      end
      if (pending) begin
        @(negedge clk);
        acc = req_valid & req_ready;
        @(posedge clk);
        #1;
        guard++;
        for (int r = 0; r < 4; r++) begin
          if (acc[r]) begin
            idx[r]++;
            if (gaps) gap[r] = $urandom_range(0, 3);
          end
        end
      end
    end
    if (guard >= 3000) fail("phase_timeout");
    req_valid = 4'd0;
    wait_idle();
  endtask

  initial begin
    int g;
    exp_t e;
    req_valid = 4'd0;
    req_last  = 4'd0;
    req_data  = 32'd0;

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", {28'd0, req_ready}, 32'd0);
    chk("rst_tx_data", {24'd0, tx_data}, 32'd0);
    chk("rst_tx_send", {31'd0, tx_send}, 32'd0);
    chk("rst_grant", {30'd0, grant_id}, 32'd0);
    chk("rst_active", {31'd0, active}, 32'd0);
    chk("rst_timeout_err", {31'd0, timeout_err}, 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Single-byte packet latency: valid c0, ready c1, send c2.
    busy_len = 5;
    @(posedge clk);
    #1;
    req_valid[0]  = 1'b1;
    req_data[7:0] = 8'h41;
    req_last[0]   = 1'b1;
    e.d = 8'h41; e.id = 0; exp_q.push_back(e);
    ptr_m = 1;
    @(negedge clk);
    chk("t1_ready_c0", {28'd0, req_ready}, 32'd0);
    @(negedge clk);
    chk("t1_ready_c1", {28'd0, req_ready}, 32'h1);
    @(posedge clk);
    #1 req_valid = 4'd0;
    @(negedge clk);
    chk("t1_send_c2", {31'd0, tx_send}, 32'd1);
    chk("t1_data", {24'd0, tx_data}, 32'h41);
    @(negedge clk);
    chk("t1_active_busy", {31'd0, active}, 32'd1);
    g = 0;
    while (tx_busy && g < 100) begin
      @(negedge clk);
      g++;
    end
    if (g >= 100) fail("t1_busy_fall");
    chk("t1_active_wait_lo", {31'd0, active}, 32'd1);
    @(negedge clk);
    chk("t1_active_drop", {31'd0, active}, 32'd0);
    chk("t1_grant", {30'd0, grant_id}, 32'd0);
    wait_idle();

    // Busy already high: lock is taken but ready withheld until busy falls.
    foreign_busy = 1'b1;
    @(posedge clk);
    #1;
    req_valid[1]   = 1'b1;
    req_data[15:8] = 8'h5A;
    req_last[1]    = 1'b1;
    e.d = 8'h5A; e.id = 1; exp_q.push_back(e);
    ptr_m = 2;
    repeat (6) @(negedge clk);
    chk("busy_blocks_ready", {28'd0, req_ready}, 32'd0);
    chk("busy_grant", {30'd0, grant_id}, 32'd1);
    chk("busy_active", {31'd0, active}, 32'd1);
    @(posedge clk);
    #1 foreign_busy = 1'b0;
    g = 0;
    do begin
      @(negedge clk);
      g++;
    end while (!req_ready[1] && g < 100);
    if (g >= 100) fail("busy_release_ready");
    @(posedge clk);
    #1 req_valid = 4'd0;
    wait_idle();

    // Contention with pointer=2: requester 3 before requester 1.
    busy_len = 0;
    run_phase(4'b1010, 1'b0, 1);

    // Randomized packets, gaps and stuck-low busy.
    for (int n = 0; n < 25; n++) begin
      stuck = ($urandom_range(0, 3) == 0);
      run_phase(4'($urandom_range(1, 15)), 1'($urandom_range(0, 1)), 0);
    end

    // Busy never rises: each byte waits BUSY_WAIT cycles then proceeds.
    stuck = 1'b1;
    send_t.delete();
    run_phase(4'b0001, 1'b0, 3);
    stuck = 1'b0;
    if (send_t.size() == 3) begin
      chk("stuck_interval_1", send_t[1] - send_t[0], BUSY_WAIT + 3);
      chk("stuck_interval_2", send_t[2] - send_t[1], BUSY_WAIT + 3);
    end else begin
      fail("stuck_send_count");
    end

    // Reset in WAIT_LO; pointer returns to 0 afterwards.
    while (ptr_m != 2) run_phase(4'(1 << ptr_m), 1'b0, 1);
    busy_len = 30;
    @(posedge clk);
    #1;
    req_valid[2]    = 1'b1;
    req_data[23:16] = 8'hA5;
    req_last[2]     = 1'b1;
    e.d = 8'hA5; e.id = 2; exp_q.push_back(e);
    g = 0;
    do begin
      @(negedge clk);
      g++;
    end while (!tx_send && g < 100);
    if (g >= 100) fail("rst_test_send");
    @(posedge clk);
    #1 req_valid = 4'd0;
    repeat (3) @(negedge clk);
    chk("pre_rst_active", {31'd0, active}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ready", {28'd0, req_ready}, 32'd0);
    chk("mid_rst_tx_data", {24'd0, tx_data}, 32'd0);
    chk("mid_rst_tx_send", {31'd0, tx_send}, 32'd0);
    chk("mid_rst_grant", {30'd0, grant_id}, 32'd0);
    chk("mid_rst_active", {31'd0, active}, 32'd0);
    chk("mid_rst_timeout_err", {31'd0, timeout_err}, 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    ptr_m = 0;
    busy_len = 0;
    run_phase(4'b1001, 1'b0, 0);

`ifdef UART_ARB_TIMEOUT_EN
    // Owner stalls after its first byte; lock released, next requester served.
    @(posedge clk);
    #1;
    req_valid       = 4'b0011;
    req_data[7:0]   = 8'h31;
    req_last[0]     = 1'b0;
    req_data[15:8]  = 8'h77;
    req_last[1]     = 1'b1;
    e.d = 8'h31; e.id = 0; exp_q.push_back(e);
    e.d = 8'h77; e.id = 1; exp_q.push_back(e);
    ptr_m = 2;
    g = 0;
    do begin
      @(negedge clk);
      g++;
    end while (!req_ready[0] && g < 100);
    @(posedge clk);
    #1 req_valid[0] = 1'b0;
    g = 0;
    do begin
      @(negedge clk);
      g++;
    end while (!timeout_err && g < 300);
    if (g >= 300) fail("timeout_pulse");
    @(negedge clk);
    chk("timeout_pulse_width", {31'd0, timeout_err}, 32'd0);
    g = 0;
    do begin
      @(negedge clk);
      g++;
    end while (!req_ready[1] && g < 100);
    chk("timeout_next_grant", {30'd0, grant_id}, 32'd1);
    @(posedge clk);
    #1 req_valid = 4'd0;
    wait_idle();
`endif

    repeat (5) @(posedge clk);
    if (exp_q.size() != 0) fail("scoreboard_leftover");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL global_watchdog: got no finish, required finish before time limit");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
